proj_qsys_jogo_nios_dbg_cmd_bridge: RTL
=======================================

# proj_qsys_jogo_nios_dbg_cmd_bridge

Parametrised system-clock side of the Nios II JTAG debug slave. It synchronises the virtual-JTAG update strobes (`vs_uir`, `vs_udr`) into `clk` and captures each `{ir, sr}` debug command. Commands are queued in a small FIFO so back-to-back JTAG updates are not lost while the CPU debug logic is busy. Each dequeued command is decoded into one-cycle `take_action[ir]` / `take_no_action[ir]` strobes with the payload on `jdo`; FIFO overflow raises a sticky flag.

## Interface
- `SR_W`, 38: debug shift-register / `jdo` width.
- `IR_W`, 2: instruction width; number of channels `NCH = 2**IR_W`.
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `SYNC_STAGES`, 2: synchroniser flops per strobe; ≥2.
- `ACT_BIT`, 35: `sr` bit selecting action (1) or no-action (0).

Ports:
- `clk` in 1: system clock; the block's only clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `ir_in` in IR_W: JTAG instruction; stable from `vs_uir` rise until next `vs_uir`.
- `sr` in SR_W: JTAG data register; stable from `vs_udr` rise until next scan.
- `vs_uir` in 1: update-IR level from the TCK domain; asynchronous.
- `vs_udr` in 1: update-DR level from the TCK domain; asynchronous.
- `cmd_ready` in 1: consumer accepts the head command.
- `overrun_clr` in 1: clears `overrun`.
- `cmd_valid` out 1: FIFO non-empty.
- `jdo` out SR_W: payload of the last dequeued command.
- `jdo_ir` out IR_W: instruction of the last dequeued command.
- `take_action` out NCH: one-hot pulse, channel = dequeued ir, `sr[ACT_BIT]=1`.
- `take_no_action` out NCH: one-hot pulse, `sr[ACT_BIT]=0`.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `overrun` out 1: sticky; a command was dropped.

## Operation
- Each strobe passes through a `SYNC_STAGES` flop chain followed by a history flop. Rise event = last sync stage & ~history.
- Arm: rise events are ignored until `SYNC_STAGES+1` cycles after `reset_n` deasserts. A strobe held high through reset does not generate a command.
- UIR rise: `ir_q <= ir_in`.
- UDR rise: push `{ir_q, sr}`. `ir_in` and `sr` are sampled on the clock edge that registers the push.
- UIR and UDR rising in the same cycle: the push uses the new `ir_in`, bypassing `ir_q`.
- Pop when `cmd_valid & cmd_ready`. On a pop:
  - `jdo`, `jdo_ir` are loaded from the head entry.
  - Exactly one bit of `take_action | take_no_action` pulses, at index = head ir.
- Push while full and no pop: command dropped, `overrun <= 1`, `level` unchanged.
- Push + pop in the same cycle when full: both accepted, `level` stays DEPTH, no overrun.
- Push + pop in the same cycle when empty: the push is not visible for popping that cycle; `level` becomes 1.
- `overrun_clr` and a dropping push in the same cycle: `overrun` stays 1 (set wins).
- Pointers wrap modulo DEPTH. `level` = wr − rd, using one extra pointer bit.

## Timing
- Reset values: `cmd_valid=0`, `jdo=0`, `jdo_ir=0`, `take_action=0`, `take_no_action=0`, `level=0`, `overrun=0`, `ir_q=0`, sync/history flops 0, arm=0.
- Latency, empty FIFO, `SYNC_STAGES=2`:
  - `vs_udr` first sampled high at edge k.
  - Push at edge k+2; `cmd_valid=1` after edge k+2. In general, push at edge k+SYNC_STAGES.
- Pop at edge p: `jdo`/strobe valid in cycle p..p+1 only. Strobes last exactly one cycle; `jdo` holds until the next pop.
- `cmd_ready` tied high: one command per cycle throughput; strobe latency from push is 1 cycle.
- `vs_udr` must stay low ≥1 clk period between rises. Narrower gaps are not guaranteed to be detected; this is an environment rule, not checked by the block.
- Reset mid-operation: FIFO contents discarded and all outputs return to reset values asynchronously.

## Structure
- Package `proj_qsys_jogo_nios_dbg_pkg`:
  - IR encodings `IR_OCIMEM=0`, `IR_TRACE=1`, `IR_BREAK=2`, `IR_TRACECTRL=3`.
  - Default `SR_W`, `ACT_BIT`.
  - Typedef for the FIFO entry `{ir, sr}`.
- Sub-module `proj_qsys_jogo_nios_dbg_sync_edge`, one instance per strobe: sync chain, history flop, rise output. Arm gating stays in the parent.
- FIFO and decode are inline in the parent.

## Test plan
- Single command: UIR with `ir_in=2`, then UDR with `sr[35]=1`, `sr=38'h2A_0000_1234`, `cmd_ready=1` → `take_action=4'b0100` for one cycle 3 edges after UDR sampled high; `jdo=38'h2A_0000_1234`, `jdo_ir=2`.
- No-action decode: `ir=0`, `sr[35]=0` → `take_no_action=4'b0001`, `take_action=0`.
- Overflow: `cmd_ready=0`, 5 UDR events → `level=4`, `overrun=1`. Then `overrun_clr` → `overrun=0`. Drain yields commands 1–4 in order; the 5th is absent.
- Full with simultaneous push/pop: `level=4`, `cmd_ready=1` in the cycle of the 5th push → `level` stays 4, `overrun=0`.
- Reset robustness: `vs_udr` high through reset release → no push, `level=0`. Assert `reset_n` low while `level=3` → all outputs 0 immediately.
- Parameter sweep: `IR_W=3`, `DEPTH=8`, `SYNC_STAGES=3`, `ir=7` → `take_action[7]` pulse, push latency 3 edges; wrap verified after 20 push/pop pairs.

Source files
------------

// File: rtl/proj_qsys_jogo_nios_dbg_pkg.sv
// Shared definitions for the Nios II debug-slave command bridge.
// Holds instruction encodings, default widths and the default command entry layout.
package proj_qsys_jogo_nios_dbg_pkg;

    localparam int IR_OCIMEM    = 0;
    localparam int IR_TRACE     = 1;
    localparam int IR_BREAK     = 2;
    localparam int IR_TRACECTRL = 3;

    localparam int SR_W_DEF     = 38;
    localparam int IR_W_DEF     = 2;
    localparam int ACT_BIT_DEF  = 35;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] sr;
    } dbg_cmd_t;

endpackage

// File: rtl/proj_qsys_jogo_nios_dbg_sync_edge.sv
// Brings an asynchronous TCK-domain level into clk and flags its rising edge.
// Latency: rise is high for one cycle, STAGES-1 edges after the level is first sampled high.
module proj_qsys_jogo_nios_dbg_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], strobe};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/proj_qsys_jogo_nios_dbg_cmd_bridge.sv
// Nios II debug-slave system side: syncs JTAG update strobes, queues {ir, sr} commands, decodes pops to per-channel strobes.
// Latency: push SYNC_STAGES edges after UDR is sampled, strobe one edge after pop; cmd_ready low holds commands, a full FIFO drops and sets overrun.
module proj_qsys_jogo_nios_dbg_cmd_bridge
    import proj_qsys_jogo_nios_dbg_pkg::*;
#(
    parameter  int SR_W        = SR_W_DEF,
    parameter  int IR_W        = IR_W_DEF,
    parameter  int DEPTH       = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int ACT_BIT     = ACT_BIT_DEF,
    localparam int NCH         = 2 ** IR_W,
    localparam int PW          = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [IR_W-1:0] ir_in,
    input  logic [SR_W-1:0] sr,
    input  logic            vs_uir,
    input  logic            vs_udr,
    input  logic            cmd_ready,
    input  logic            overrun_clr,
    output logic            cmd_valid,
    output logic [SR_W-1:0] jdo,
    output logic [IR_W-1:0] jdo_ir,
    output logic [NCH-1:0]  take_action,
    output logic [NCH-1:0]  take_no_action,
    output logic [PW:0]     level,
    output logic            overrun
);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] sr;
    } entry_t;

    localparam int            ARM_N   = SYNC_STAGES + 1;
    localparam int            AW      = $clog2(ARM_N + 1);
    localparam logic [NCH-1:0] CH0    = NCH'(1);

    logic          uir_rise, udr_rise;
    logic          armed, uir_vld, udr_vld;
    logic [AW-1:0] arm_cnt;
    logic [IR_W-1:0] ir_q;
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          full, pop, push_ok, drop;
    entry_t        push_dat, head;
    entry_t        mem [DEPTH];

    proj_qsys_jogo_nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (vs_uir),
        .rise    (uir_rise)
    );

    proj_qsys_jogo_nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (vs_udr),
        .rise    (udr_rise)
    );

    // A strobe already high at reset release would look like a fresh rise once
    // the chain fills; the arm window outlasts that false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    assign armed   = (arm_cnt == AW'(ARM_N));
    assign uir_vld = uir_rise & armed;
    assign udr_vld = udr_rise & armed;

    assign push_dat.ir = uir_vld ? ir_in : ir_q;
    assign push_dat.sr = sr;

    assign level     = wr_ptr - rd_ptr;
    assign cmd_valid = (level != '0);
    assign full      = (level == (PW+1)'(DEPTH));
    assign pop       = cmd_valid & cmd_ready;
    assign push_ok   = udr_vld & (~full | pop);
    assign drop      = udr_vld & full & ~pop;
    assign head      = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q           <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            jdo            <= '0;
            jdo_ir         <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            overrun        <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (uir_vld) begin
                ir_q <= ir_in;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                jdo    <= head.sr;
                jdo_ir <= head.ir;
                if (head.sr[ACT_BIT]) begin
                    take_action <= CH0 << head.ir;
                end else begin
                    take_no_action <= CH0 << head.ir;
                end
            end
            // A drop in the same cycle as a clear must stay visible.
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
